// File: rtl/bf_pkg.sv
// Shared Brainf*ck definitions: opcodes, ASCII command bytes, loader error codes,
// loader state encoding and the byte-to-opcode decoder.
package bf_pkg;

  localparam logic [2:0] OP_INC   = 3'd0;
  localparam logic [2:0] OP_DEC   = 3'd1;
  localparam logic [2:0] OP_RIGHT = 3'd2;
  localparam logic [2:0] OP_LEFT  = 3'd3;
  localparam logic [2:0] OP_LOOP  = 3'd4;
  localparam logic [2:0] OP_END   = 3'd5;
  localparam logic [2:0] OP_OUT   = 3'd6;
  localparam logic [2:0] OP_IN    = 3'd7;

  localparam logic [7:0] CH_INC   = 8'h2B;
  localparam logic [7:0] CH_DEC   = 8'h2D;
  localparam logic [7:0] CH_RIGHT = 8'h3E;
  localparam logic [7:0] CH_LEFT  = 8'h3C;
  localparam logic [7:0] CH_LOOP  = 8'h5B;
  localparam logic [7:0] CH_END   = 8'h5D;
  localparam logic [7:0] CH_OUT   = 8'h2E;
  localparam logic [7:0] CH_IN    = 8'h2C;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
  localparam logic [1:0] ERR_UNMATCHED = 2'd2;
  localparam logic [1:0] ERR_NEST      = 2'd3;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] op;
  } bf_cmd_t;

  function automatic bf_cmd_t bf_decode(input logic [7:0] b);
    bf_cmd_t d;
    d.valid = 1'b1;
    d.op    = OP_INC;
    case (b)
      CH_INC:   d.op = OP_INC;
      CH_DEC:   d.op = OP_DEC;
      CH_RIGHT: d.op = OP_RIGHT;
      CH_LEFT:  d.op = OP_LEFT;
      CH_LOOP:  d.op = OP_LOOP;
      CH_END:   d.op = OP_END;
      CH_OUT:   d.op = OP_OUT;
      CH_IN:    d.op = OP_IN;
      default:  d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bf_bracket_stack.sv
// LIFO of open-bracket addresses with full/empty flags; top reads combinationally.
module bf_bracket_stack #(
  parameter int DEPTH = 16,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_m1;

  assign full   = (ptr == PTR_W'(DEPTH));
  assign empty  = (ptr == '0);
  assign ptr_m1 = ptr - PTR_W'(1);
  assign top    = empty ? '0 : mem[ptr_m1[PTR_W-2:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + PTR_W'(1);
    end else if (pop && !empty) begin
      ptr <= ptr_m1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[ptr[PTR_W-2:0]] <= din;
    end
  end

endmodule

// File: rtl/bf_program_loader.sv
// Filters UART bytes to BF opcodes, writes them to program memory and checks brackets on RUN.
// Optional jump-table output enabled by defining BF_LOADER_JUMP_TABLE_EN.
module bf_program_loader
  import bf_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int MAX_NEST = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_VALID,
  input  logic [7:0]        RX_DATA,
  input  logic              RUN,
  output logic              PMEM_WE,
  output logic [ADDR_W-1:0] PMEM_ADDR,
  output logic [2:0]        PMEM_DATA,
  output logic [ADDR_W:0]   PROG_LEN,
  output logic              START,
  output logic              LOADED,
  output logic [1:0]        ERR
`ifdef BF_LOADER_JUMP_TABLE_EN
  ,
  output logic              JT_WE,
  output logic [ADDR_W-1:0] JT_OPEN,
  output logic [ADDR_W-1:0] JT_CLOSE
`endif
);
  localparam int DEPTH_W = $clog2(MAX_NEST) + 1;
  localparam logic [ADDR_W:0]    CAPACITY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [DEPTH_W-1:0] NEST_MAX = DEPTH_W'(MAX_NEST);

  loader_state_t      state, state_next;
  logic [ADDR_W:0]    count, count_next;
  logic [DEPTH_W-1:0] depth, depth_next;
  logic               run_pending, run_pending_next;
  logic               run_s1, run_s2, run_s3;
  logic               run_edge, run_req, accept;
  logic               we_next, start_next;
  logic [1:0]         err_next;
  bf_cmd_t            cmd;

  assign cmd      = bf_decode(RX_DATA);
  assign run_edge = run_s2 & ~run_s3;
  assign run_req  = run_edge | run_pending;
  assign PROG_LEN = count;
  assign LOADED   = (state == ST_DONE);

  always_comb begin
    state_next       = state;
    count_next       = count;
    depth_next       = depth;
    run_pending_next = 1'b0;
    we_next          = 1'b0;
    start_next       = 1'b0;
    err_next         = ERR;
    accept           = 1'b0;
    if (state == ST_LOAD) begin
      if (RX_VALID && cmd.valid) begin
        if (count == CAPACITY) begin
          state_next = ST_ERROR;
          err_next   = ERR_OVERFLOW;
        end else if (cmd.op == OP_LOOP && depth == NEST_MAX) begin
          state_next = ST_ERROR;
          err_next   = ERR_NEST;
        end else if (cmd.op == OP_END && depth == '0) begin
          state_next = ST_ERROR;
          err_next   = ERR_UNMATCHED;
        end else begin
          accept     = 1'b1;
          we_next    = 1'b1;
          count_next = count + (ADDR_W+1)'(1);
          if (cmd.op == OP_LOOP) depth_next = depth + DEPTH_W'(1);
          if (cmd.op == OP_END)  depth_next = depth - DEPTH_W'(1);
        end
      end
      // A RUN edge coinciding with an accepted byte is deferred one cycle so the
      // balance check sees the updated depth and START trails the write.
      if (state_next == ST_LOAD && run_req) begin
        if (accept) begin
          run_pending_next = 1'b1;
        end else if (depth != '0) begin
          state_next = ST_ERROR;
          err_next   = ERR_NEST;
        end else begin
          state_next = ST_DONE;
          start_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_LOAD;
      count       <= '0;
      depth       <= '0;
      run_pending <= 1'b0;
      run_s1      <= 1'b0;
      run_s2      <= 1'b0;
      run_s3      <= 1'b0;
      PMEM_WE     <= 1'b0;
      PMEM_ADDR   <= '0;
      PMEM_DATA   <= '0;
      START       <= 1'b0;
      ERR         <= ERR_NONE;
    end else begin
      state       <= state_next;
      count       <= count_next;
      depth       <= depth_next;
      run_pending <= run_pending_next;
      run_s1      <= RUN;
      run_s2      <= run_s1;
      run_s3      <= run_s2;
      PMEM_WE     <= we_next;
      START       <= start_next;
      ERR         <= err_next;
      if (we_next) begin
        PMEM_ADDR <= count[ADDR_W-1:0];
        PMEM_DATA <= cmd.op;
      end
    end
  end

`ifdef BF_LOADER_JUMP_TABLE_EN
  logic              stack_push, stack_pop, stack_full, stack_empty;
  logic [ADDR_W-1:0] stack_top;

  assign stack_push = we_next && (cmd.op == OP_LOOP) && !stack_full;
  assign stack_pop  = we_next && (cmd.op == OP_END) && !stack_empty;

  bf_bracket_stack #(
    .DEPTH (MAX_NEST),
    .W     (ADDR_W)
  ) u_stack (
    .clk   (CLK),
    .rst   (RST),
    .push  (stack_push),
    .pop   (stack_pop),
    .din   (count[ADDR_W-1:0]),
    .top   (stack_top),
    .full  (stack_full),
    .empty (stack_empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      JT_WE    <= 1'b0;
      JT_OPEN  <= '0;
      JT_CLOSE <= '0;
    end else begin
      JT_WE <= stack_pop;
      if (stack_pop) begin
        JT_OPEN  <= stack_top;
        JT_CLOSE <= count[ADDR_W-1:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_bf_program_loader.sv
// Self-checking bench for bf_program_loader: opcode table, scoreboard of memory writes,
// and hand sequences for bracket errors, overflow, RUN timing and resets.
module tb_bf_program_loader;
  import bf_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST = 1'b1;
  logic       RX_VALID = 1'b0;
  logic [7:0] RX_DATA = 8'h00;
  logic       RUN = 1'b0;
  logic       PMEM_WE, START, LOADED;
  logic [9:0] PMEM_ADDR;
  logic [2:0] PMEM_DATA;
  logic [10:0] PROG_LEN;
  logic [1:0] ERR;
`ifdef BF_LOADER_JUMP_TABLE_EN
  logic       JT_WE;
  logic [9:0] JT_OPEN, JT_CLOSE;
`endif

  bf_program_loader #(.ADDR_W(10), .MAX_NEST(16)) dut (
    .CLK(CLK), .RST(RST), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA), .RUN(RUN),
    .PMEM_WE(PMEM_WE), .PMEM_ADDR(PMEM_ADDR), .PMEM_DATA(PMEM_DATA),
    .PROG_LEN(PROG_LEN), .START(START), .LOADED(LOADED), .ERR(ERR)
`ifdef BF_LOADER_JUMP_TABLE_EN
    , .JT_WE(JT_WE), .JT_OPEN(JT_OPEN), .JT_CLOSE(JT_CLOSE)
`endif
  );

  logic       rx2_valid = 1'b0;
  logic [7:0] rx2_data = 8'h00;
  logic       run2 = 1'b0;
  logic       we2, start2, loaded2;
  logic [1:0] addr2;
  logic [2:0] data2;
  logic [2:0] len2;
  logic [1:0] err2;
`ifdef BF_LOADER_JUMP_TABLE_EN
  logic       jt_we2;
  logic [1:0] jt_open2, jt_close2;
`endif

  bf_program_loader #(.ADDR_W(2), .MAX_NEST(16)) dut_small (
    .CLK(CLK), .RST(RST), .RX_VALID(rx2_valid), .RX_DATA(rx2_data), .RUN(run2),
    .PMEM_WE(we2), .PMEM_ADDR(addr2), .PMEM_DATA(data2),
    .PROG_LEN(len2), .START(start2), .LOADED(loaded2), .ERR(err2)
`ifdef BF_LOADER_JUMP_TABLE_EN
    , .JT_WE(jt_we2), .JT_OPEN(jt_open2), .JT_CLOSE(jt_close2)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct { logic [9:0] addr; logic [2:0] op; } wr_t;
  wr_t exp_q[$];
  wr_t w;
  int unsigned exp_addr = 0;
  int start_cnt = 0;
  int cyc = 0, last_wr_cyc = -10, start_cyc = -10;
  int n2 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every DUT write must match the oldest expected write.
  always @(negedge CLK) begin
    cyc++;
    if (!RST && PMEM_WE) begin
      last_wr_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d expected no write", PMEM_ADDR, PMEM_DATA);
      end else begin
        w = exp_q.pop_front();
        if (PMEM_ADDR !== w.addr || PMEM_DATA !== w.op) begin
          errors++;
          $display("FAIL pmem_write: got addr=%0d data=%0d expected addr=%0d data=%0d",
                   PMEM_ADDR, PMEM_DATA, w.addr, w.op);
        end
      end
    end
    if (!RST && START) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (!RST && we2) begin
      checks++;
      if (addr2 !== n2[1:0] || data2 !== OP_INC) begin
        errors++;
        $display("FAIL small_write: got addr=%0d data=%0d expected addr=%0d data=0", addr2, data2, n2);
      end
      n2++;
    end
  end

  task automatic expect_wr(input logic [2:0] op);
    exp_q.push_back('{addr: exp_addr[9:0], op: op});
    exp_addr++;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge CLK); #1;
    RX_VALID = 1'b1;
    RX_DATA  = b;
    @(posedge CLK); #1;
    RX_VALID = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b);
    @(posedge CLK); #1;
    rx2_valid = 1'b1;
    rx2_data  = b;
    @(posedge CLK); #1;
    rx2_valid = 1'b0;
  endtask

  task automatic press_run();
    @(posedge CLK); #1;
    RUN = 1'b1;
    repeat (6) @(posedge CLK);
    #1 RUN = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    check("pending_writes_at_reset", exp_q.size(), 0);
    exp_q.delete();
    exp_addr  = 0;
    start_cnt = 0;
  endtask

  typedef struct { logic [7:0] b; logic cmd; logic [2:0] op; int unsigned len; } vec_t;
  vec_t tbl[13];
  logic [7:0] prog1[6];
  logic [2:0] ops1[6];

  initial begin
    tbl[0]  = '{8'h2B, 1'b1, 3'd0, 1};
    tbl[1]  = '{8'h2D, 1'b1, 3'd1, 2};
    tbl[2]  = '{8'h3E, 1'b1, 3'd2, 3};
    tbl[3]  = '{8'h3C, 1'b1, 3'd3, 4};
    tbl[4]  = '{8'h5B, 1'b1, 3'd4, 5};
    tbl[5]  = '{8'h5D, 1'b1, 3'd5, 6};
    tbl[6]  = '{8'h2E, 1'b1, 3'd6, 7};
    tbl[7]  = '{8'h2C, 1'b1, 3'd7, 8};
    tbl[8]  = '{8'h61, 1'b0, 3'd0, 8};
    tbl[9]  = '{8'h0A, 1'b0, 3'd0, 8};
    tbl[10] = '{8'h00, 1'b0, 3'd0, 8};
    tbl[11] = '{8'hFF, 1'b0, 3'd0, 8};
    tbl[12] = '{8'h7B, 1'b0, 3'd0, 8};
    prog1 = '{8'h2B, 8'h2B, 8'h2E, 8'h5B, 8'h2D, 8'h5D};
    ops1  = '{3'd0, 3'd0, 3'd6, 3'd4, 3'd1, 3'd5};

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_we", PMEM_WE, 0);
    check("rst_len", PROG_LEN, 0);
    check("rst_start", START, 0);
    check("rst_loaded", LOADED, 0);
    check("rst_err", ERR, 0);
    RST = 1'b0;

    // Opcode table, including dropped bytes
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].cmd) expect_wr(tbl[i].op);
      send(tbl[i].b);
      @(negedge CLK);
      check("table_prog_len", PROG_LEN, tbl[i].len);
    end
    press_run();
    check("table_start", start_cnt, 1);
    check("table_loaded", LOADED, 1);
    check("table_err", ERR, 0);
    send(8'h2B);
    press_run();
    check("done_len_hold", PROG_LEN, 8);
    check("done_no_restart", start_cnt, 1);

    // "++.[-]"
    do_reset();
    for (int i = 0; i < 6; i++) begin
      expect_wr(ops1[i]);
      send(prog1[i]);
`ifdef BF_LOADER_JUMP_TABLE_EN
      if (i == 5) begin
        @(negedge CLK);
        check("jt_we", JT_WE, 1);
        check("jt_open", JT_OPEN, 3);
        check("jt_close", JT_CLOSE, 5);
      end
`endif
    end
    press_run();
    check("p1_len", PROG_LEN, 6);
    check("p1_start", start_cnt, 1);
    check("p1_err", ERR, 0);

    // "a+\n-"
    do_reset();
    send(8'h61);
    expect_wr(OP_INC); send(8'h2B);
    send(8'h0A);
    expect_wr(OP_DEC); send(8'h2D);
    press_run();
    check("p2_len", PROG_LEN, 2);
    check("p2_start", start_cnt, 1);

    // Unmatched ']' is sticky
    do_reset();
    send(8'h5D);
    @(negedge CLK);
    check("unmatched_err", ERR, 2);
    check("unmatched_len", PROG_LEN, 0);
    press_run();
    send(8'h2B);
    check("unmatched_no_start", start_cnt, 0);
    check("unmatched_err_hold", ERR, 2);
    do_reset();
    check("after_rst_err", ERR, 0);
    check("after_rst_loaded", LOADED, 0);

    // Unbalanced on RUN
    expect_wr(OP_LOOP); send(8'h5B);
    expect_wr(OP_LOOP); send(8'h5B);
    expect_wr(OP_INC);  send(8'h2B);
    press_run();
    check("unbal_err", ERR, 3);
    check("unbal_no_start", start_cnt, 0);

    // Nesting overflow on the 17th '['
    do_reset();
    for (int i = 0; i < 16; i++) begin
      expect_wr(OP_LOOP);
      send(8'h5B);
    end
    @(negedge CLK);
    check("nest16_err", ERR, 0);
    send(8'h5B);
    @(negedge CLK);
    check("nest17_err", ERR, 3);
    check("nest17_len", PROG_LEN, 16);

    // Byte and RUN edge in the same cycle: START one cycle after the write
    do_reset();
    @(posedge CLK); #1;
    RUN = 1'b1;
    @(posedge CLK);
    @(posedge CLK); #1;
    expect_wr(OP_INC);
    RX_VALID = 1'b1;
    RX_DATA  = 8'h2B;
    @(posedge CLK); #1;
    RX_VALID = 1'b0;
    repeat (5) @(posedge CLK);
    #1 RUN = 1'b0;
    check("same_cycle_start", start_cnt, 1);
    check("same_cycle_start_delay", start_cyc - last_wr_cyc, 1);
    check("same_cycle_len", PROG_LEN, 1);

    // Reset between bytes restarts the address counter
    do_reset();
    expect_wr(OP_INC); send(8'h2B);
    expect_wr(OP_INC); send(8'h2B);
    do_reset();
    expect_wr(OP_INC); send(8'h2B);
    @(negedge CLK);
    check("rst_mid_len", PROG_LEN, 1);

    // RUN held high: a single START, empty program is legal
    do_reset();
    @(posedge CLK); #1;
    RUN = 1'b1;
    repeat (1000) @(posedge CLK);
    #1 RUN = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("held_run_start", start_cnt, 1);
    check("held_run_len", PROG_LEN, 0);
    check("held_run_loaded", LOADED, 1);

    // Small instance: capacity 4, overflow on the fifth '+'
    for (int i = 0; i < 4; i++) send2(8'h2B);
    @(negedge CLK);
    check("small_err_full", err2, 0);
    send2(8'h2B);
    repeat (2) @(negedge CLK);
    check("small_err_overflow", err2, 1);
    check("small_len", len2, 4);
    check("small_writes", n2, 4);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
